show_seg: RTL and testbench

SHOW_SEG -- requirements
Module: show_seg

---
 rtl/show_seg.sv | 120 ++++++++++++
 tb/tb_show_seg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/show_seg.sv
`default_nettype none
// ============================================================================
// Module      : show_seg
// Description : Eight-digit multiplexed hex display driver for a common-anode
//               seven-segment display. It shows each digit for SCAN_DIV clk
//               cycles in turn, digit 0 (rightmost) first. The 32-bit
//               display value is captured once per frame, so a change to
//               Leddata part-way through a frame does not tear the display.
//               Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading
//               zero digits above digit 0).
// Revision    : 1.0 - initial release
// ============================================================================
module show_seg #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Leddata,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);

    // Last count value of a digit slot.
    localparam logic [23:0] TERM_CNT = 24'(SCAN_DIV - 1);

    // Active-low segment code with the decimal point (bit 7) held off.
    function automatic logic [7:0] hex_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    logic [23:0] cnt;
    logic [2:0]  idx;
    logic [31:0] shd;
    logic        ld;

    logic [23:0] cnt_next;
    logic [2:0]  idx_next;
    logic [31:0] shd_next;
    logic        term;
    logic [3:0]  nib_next;
    logic        blank_next;
    logic [7:0]  seg_next;
    logic [7:0]  an_next;

    // Next-state scan position, frame capture and output decode.
    always_comb begin
        term = (cnt == TERM_CNT);

        if (ld) begin
            // The capture edge is the first cycle of digit 0, so the slot
            // counter starts from zero here and the first slot is full length.
            cnt_next = 24'd0;
            idx_next = 3'd0;
            shd_next = Leddata;
        end else begin
            cnt_next = term ? 24'd0 : cnt + 24'd1;
            idx_next = term ? idx + 3'd1 : idx;
            shd_next = (term && (idx == 3'd7)) ? Leddata : shd;
        end

        nib_next = shd_next[{idx_next, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank when it and every digit above it are zero;
        // digit 0 always stays lit so a zero value still reads "0".
        blank_next = (idx_next != 3'd0) &&
                     ((shd_next >> {idx_next, 2'b00}) == 32'd0);
`else
        blank_next = 1'b0;
`endif

        if (blank_next) begin
            an_next  = 8'hFF;
            seg_next = 8'hFF;
        end else begin
            an_next  = ~(8'd1 << idx_next);
            seg_next = hex_code(nib_next);
        end
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= 24'd0;
            idx <= 3'd0;
            shd <= 32'd0;
            ld  <= 1'b1;
            AN  <= 8'hFF;
            SEG <= 8'hFF;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
            shd <= shd_next;
            ld  <= 1'b0;
            AN  <= an_next;
            SEG <= seg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_show_seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_show_seg
// Description : Self-checking bench for show_seg with SCAN_DIV = 4. A frame
//               model indexed by cycles-since-reset predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_show_seg;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] Leddata = 32'd0;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    always #5 clk = ~clk;

    show_seg #(.SCAN_DIV(D)) dut (
        .clk     (clk),
        .clr     (clr),
        .Leddata (Leddata),
        .SEG     (SEG),
        .AN      (AN)
    );

    localparam logic [7:0] HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int checks = 0;
    int errors = 0;

    // Model: cycles since reset release and the value captured for the frame.
    int          n = 0;
    logic [31:0] mshd = 32'd0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit blanked(input logic [31:0] v, input int dig);
`ifdef LEADING_ZERO_BLANK_EN
        return (dig > 0) && ((v >> (4 * dig)) == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: apply inputs, predict outputs, compare after the edge.
    task automatic tick(input logic c, input logic [31:0] d);
        logic [7:0] es;
        logic [7:0] ea;
        int         dig;
        bit         bl;
        clr     = c;
        Leddata = d;
        if (c) begin
            es   = 8'hFF;
            ea   = 8'hFF;
            bl   = 1'b1;
            n    = 0;
            mshd = 32'd0;
        end else begin
            if (n % (8 * D) == 0) mshd = d;
            dig = (n / D) % 8;
            bl  = blanked(mshd, dig);
            if (bl) begin
                es = 8'hFF;
                ea = 8'hFF;
            end else begin
                es = HEX[4'(mshd >> (4 * dig))];
                ea = ~(8'd1 << dig);
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("seg", SEG, es);
        check("an", AN, ea);
        if (!bl) begin
            checks++;
            if ($countones(~AN) != 1) begin
                errors++;
                $display("FAIL an_onehot: got %h expected exactly one low bit", AN);
            end
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [63:0] segs;   // digit 7 code in the top byte, digit 0 lowest
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] cur;
    logic [31:0] mask;
    logic [7:0]  texp;
    logic [7:0]  taexp;

    initial begin
        vecs[0] = '{32'h12345678, 64'hF9_A4_B0_99_92_82_F8_80};
        vecs[1] = '{32'h0123ABCD, 64'hC0_F9_A4_B0_88_83_C6_A1};
        vecs[2] = '{32'hFFFFFFFF, 64'h8E_8E_8E_8E_8E_8E_8E_8E};
        vecs[3] = '{32'h00000000, 64'hC0_C0_C0_C0_C0_C0_C0_C0};

        // Table vectors: one reset cycle, then a full frame per record.
        for (int v = 0; v < 4; v++) begin
            tick(1'b1, 32'd0);
            for (int c = 0; c < 8 * D + 1; c++) begin
                tick(1'b0, vecs[v].data);
                begin
                    int dg;
                    dg = (c / D) % 8;
                    if (blanked(vecs[v].data, dg)) begin
                        texp  = 8'hFF;
                        taexp = 8'hFF;
                    end else begin
                        texp  = vecs[v].segs[8 * dg +: 8];
                        taexp = ~(8'd1 << dg);
                    end
                    check("tbl_seg", SEG, texp);
                    check("tbl_an", AN, taexp);
                end
            end
        end

        // Mid-frame data change: current frame keeps the old capture.
        tick(1'b1, 32'd0);
        for (int c = 0; c < 8 * D + 2; c++) begin
            tick(1'b0, (c < 3 * D) ? 32'h12345678 : 32'hFFFFFFFF);
            if (c == 4 * D) check("midframe_d4", SEG, 8'h99);
            if (c == 7 * D) check("midframe_d7", SEG, 8'hF9);
            if (c == 8 * D) check("next_frame", SEG, 8'h8E);
        end

        // Reset held three cycles in the middle of digit 5.
        tick(1'b1, 32'd0);
        for (int c = 0; c < 5 * D + 1; c++) tick(1'b0, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 32'h12345678);
            check("rst_an", AN, 8'hFF);
        end
        tick(1'b0, 32'hCAFE0009);
        check("rel_an", AN, 8'hFE);
        check("rel_seg", SEG, 8'h90);
        for (int c = 0; c < D; c++) tick(1'b0, 32'h0);
        check("rel_d1_an", AN, 8'hFD);
        check("rel_d1_seg", SEG, 8'hC0);

`ifdef LEADING_ZERO_BLANK_EN
        tick(1'b1, 32'd0);
        for (int c = 0; c < 8 * D; c++) tick(1'b0, 32'h0000000A);
        tick(1'b1, 32'd0);
        tick(1'b0, 32'h0);
        check("zero_d0", SEG, 8'hC0);
`endif

        // Randomised traffic with occasional resets and data changes.
        cur = $urandom;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mask = 32'hFFFFFFFF;
                    1:       mask = 32'h0000FFFF;
                    2:       mask = 32'h0000000F;
                    default: mask = 32'h00000000;
                endcase
                cur = $urandom & mask;
            end
            tick($urandom_range(0, 79) == 0, cur);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
